// File: rtl/laser_host.sv
// Host-side loader, feeder and scorer for the two-circle LASER search engine.
// Define LASER_HOST_TIMEOUT_EN to bound the WAIT state and report aborted runs on RES_ERR.
module laser_host #(
  parameter int unsigned NUM_OBJ     = 40,
  parameter int unsigned RADIUS_SQ   = 16,
  parameter int unsigned TIMEOUT_CYC = 16383
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_VALID,
  input  logic [5:0] LD_ADDR,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  input  logic       START,
  output logic       L_RST,
  output logic [3:0] L_X,
  output logic [3:0] L_Y,
  input  logic [3:0] L_C1X,
  input  logic [3:0] L_C1Y,
  input  logic [3:0] L_C2X,
  input  logic [3:0] L_C2Y,
  input  logic       L_DONE,
  output logic       BUSY,
  output logic       RES_VALID,
  output logic [7:0] RES_C1,
  output logic [7:0] RES_C2,
  output logic [5:0] RES_COUNT,
  output logic       RES_ERR
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RSTD   = 3'd1;
  localparam logic [2:0] FEED   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] SCORE  = 3'd4;
  localparam logic [2:0] RESULT = 3'd5;

  localparam logic [5:0] LAST_IDX = 6'(NUM_OBJ - 1);
  localparam logic [5:0] NUM_PTS  = 6'(NUM_OBJ);
  localparam logic [8:0] RAD_SQ   = 9'(RADIUS_SQ);

  logic [2:0] state;
  logic [5:0] idx;
  logic [5:0] rd_idx;
  logic [7:0] pt;
  logic [7:0] mem [NUM_OBJ];
  logic       loadable;
  logic       covered;

  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] sx;
    logic [7:0] sy;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    sx = {4'd0, dx} * {4'd0, dx};
    sy = {4'd0, dy} * {4'd0, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  assign loadable  = (state == IDLE) || (state == RESULT);
  assign L_RST     = (state == IDLE) || (state == RSTD) || (state == RESULT);
  assign BUSY      = !loadable;
  assign RES_VALID = (state == RESULT);

  // FEED registers the next point one edge ahead, so it looks at idx+1.
  assign rd_idx = ((state == FEED) && (idx != LAST_IDX)) ? idx + 6'd1 : idx;
  assign pt     = mem[rd_idx];

  assign covered = (dist_sq(pt[3:0], pt[7:4], RES_C1[3:0], RES_C1[7:4]) <= RAD_SQ) ||
                   (dist_sq(pt[3:0], pt[7:4], RES_C2[3:0], RES_C2[7:4]) <= RAD_SQ);

  always_ff @(posedge CLK) begin
    if (loadable && LD_VALID && (LD_ADDR < NUM_PTS)) begin
      mem[LD_ADDR] <= {LD_Y, LD_X};
    end
  end

`ifdef LASER_HOST_TIMEOUT_EN
  localparam logic [13:0] TO_LAST = 14'(TIMEOUT_CYC - 1);
  logic [13:0] to_cnt;
  logic        res_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt    <= '0;
      res_err_q <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT) ? to_cnt + 14'd1 : 14'd0;
      if (loadable && START) begin
        res_err_q <= 1'b0;
      end else if ((state == WAIT) && !L_DONE && (to_cnt == TO_LAST)) begin
        res_err_q <= 1'b1;
      end
    end
  end

  assign RES_ERR = res_err_q;
`else
  assign RES_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      L_X       <= '0;
      L_Y       <= '0;
      RES_C1    <= '0;
      RES_C2    <= '0;
      RES_COUNT <= '0;
    end else begin
      case (state)
        IDLE, RESULT: begin
          if (START) begin
            state <= RSTD;
            idx   <= '0;
          end
        end
        RSTD: begin
          {L_Y, L_X} <= pt;
          state      <= FEED;
        end
        FEED: begin
          if (idx == LAST_IDX) begin
            state <= WAIT;
          end else begin
            idx        <= idx + 6'd1;
            {L_Y, L_X} <= pt;
          end
        end
        WAIT: begin
          if (L_DONE) begin
            RES_C1    <= {L_C1Y, L_C1X};
            RES_C2    <= {L_C2Y, L_C2X};
            RES_COUNT <= '0;
            idx       <= '0;
            state     <= SCORE;
          end
`ifdef LASER_HOST_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            RES_C1    <= '0;
            RES_C2    <= '0;
            RES_COUNT <= '0;
            state     <= RESULT;
          end
`endif
        end
        SCORE: begin
          if (covered) begin
            RES_COUNT <= RES_COUNT + 6'd1;
          end
          if (idx == LAST_IDX) begin
            state <= RESULT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// Self-checking bench for laser_host: run-level behavioural model, per-cycle compare and an
// engine stand-in that pulses L_DONE a fixed number of cycles after L_RST drops.
module tb_laser_host;

  localparam int TB_TO = 100;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LD_VALID = 1'b0;
  logic [5:0] LD_ADDR = '0;
  logic [3:0] LD_X = '0;
  logic [3:0] LD_Y = '0;
  logic       START = 1'b0;
  logic       L_RST;
  logic [3:0] L_X, L_Y;
  logic [3:0] L_C1X = '0, L_C1Y = '0, L_C2X = '0, L_C2Y = '0;
  logic       L_DONE = 1'b0;
  logic       BUSY, RES_VALID, RES_ERR;
  logic [7:0] RES_C1, RES_C2;
  logic [5:0] RES_COUNT;

  laser_host #(
    .NUM_OBJ    (40),
    .RADIUS_SQ  (16),
    .TIMEOUT_CYC(TB_TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LD_VALID (LD_VALID),
    .LD_ADDR  (LD_ADDR),
    .LD_X     (LD_X),
    .LD_Y     (LD_Y),
    .START    (START),
    .L_RST    (L_RST),
    .L_X      (L_X),
    .L_Y      (L_Y),
    .L_C1X    (L_C1X),
    .L_C1Y    (L_C1Y),
    .L_C2X    (L_C2X),
    .L_C2Y    (L_C2Y),
    .L_DONE   (L_DONE),
    .BUSY     (BUSY),
    .RES_VALID(RES_VALID),
    .RES_C1   (RES_C1),
    .RES_C2   (RES_C2),
    .RES_COUNT(RES_COUNT),
    .RES_ERR  (RES_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Engine stand-in: answers L_DONE on the eng_lat-th cycle after L_RST falls.
  int eng_cnt = 0;
  int eng_lat = 44;
  bit eng_mute = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (L_RST) begin
      eng_cnt = 0;
      L_DONE  = 1'b0;
    end else begin
      eng_cnt++;
      L_DONE = !eng_mute && (eng_cnt == eng_lat);
    end
  end

  // Run-level model. m_cyc counts cycles since an accepted START (1 = engine-reset cycle,
  // 2..41 = point k=m_cyc-2 on the bus); 0 means idle or result.
  logic [7:0] m_buf [40];
  int         m_cyc = 0;
  int         m_done_cyc = 0;
  bit         m_valid = 1'b0;
  bit         m_err = 1'b0;
  logic [7:0] m_c1 = '0, m_c2 = '0;
  int         m_count = 0;

  function automatic int score(input logic [7:0] c1, input logic [7:0] c2);
    int n = 0;
    for (int j = 0; j < 40; j++) begin
      int x = int'(m_buf[j][3:0]);
      int y = int'(m_buf[j][7:4]);
      int d1 = (x - int'(c1[3:0])) ** 2 + (y - int'(c1[7:4])) ** 2;
      int d2 = (x - int'(c2[3:0])) ** 2 + (y - int'(c2[7:4])) ** 2;
      if (d1 <= 16 || d2 <= 16) n++;
    end
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_cyc = 0; m_done_cyc = 0; m_valid = 0; m_err = 0;
      m_c1 = '0; m_c2 = '0; m_count = 0;
    end else if (m_cyc == 0) begin
      if (LD_VALID && LD_ADDR < 40) m_buf[LD_ADDR] = {LD_Y, LD_X};
      if (START) begin
        m_cyc = 1; m_done_cyc = 0; m_valid = 0; m_err = 0;
      end
    end else begin
      bit aborted = 1'b0;
      if (m_done_cyc == 0 && m_cyc >= 42 && L_DONE) begin
        m_c1 = {L_C1Y, L_C1X};
        m_c2 = {L_C2Y, L_C2X};
        m_count = score(m_c1, m_c2);
        m_done_cyc = m_cyc;
      end
`ifdef LASER_HOST_TIMEOUT_EN
      else if (m_done_cyc == 0 && m_cyc == 41 + TB_TO) begin
        aborted = 1'b1;
        m_err = 1; m_valid = 1; m_c1 = '0; m_c2 = '0; m_count = 0;
      end
`endif
      m_cyc = aborted ? 0 : m_cyc + 1;
      if (m_done_cyc != 0 && m_cyc == m_done_cyc + 41) begin
        m_cyc = 0;
        m_valid = 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_l_rst", L_RST, 1);
      chk("rst_busy", BUSY, 0);
      chk("rst_valid", RES_VALID, 0);
      chk("rst_err", RES_ERR, 0);
      chk("rst_c1", RES_C1, 0);
      chk("rst_c2", RES_C2, 0);
      chk("rst_count", RES_COUNT, 0);
      chk("rst_lxy", {L_Y, L_X}, 0);
    end else begin
      chk("busy", BUSY, m_cyc != 0);
      chk("l_rst", L_RST, m_cyc <= 1);
      chk("res_valid", RES_VALID, m_valid);
      chk("res_err", RES_ERR, m_err);
      if (m_cyc >= 2 && m_cyc <= 41) chk("feed_pt", {L_Y, L_X}, m_buf[m_cyc-2]);
      else if (m_cyc >= 42) chk("hold_pt", {L_Y, L_X}, m_buf[39]);
      if (m_valid) begin
        chk("res_c1", RES_C1, m_c1);
        chk("res_c2", RES_C2, m_c2);
        chk("res_count", RES_COUNT, m_count);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int a, input int x, input int y);
    LD_VALID = 1'b1; LD_ADDR = 6'(a); LD_X = 4'(x); LD_Y = 4'(y);
    tick();
    LD_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic set_eng(input int c1x, input int c1y, input int c2x, input int c2y);
    L_C1X = 4'(c1x); L_C1Y = 4'(c1y); L_C2X = 4'(c2x); L_C2Y = 4'(c2y);
  endtask

  task automatic wait_result(input string nm);
    int n = 0;
    while (!RES_VALID && n < 400) begin
      tick();
      n++;
    end
    chk(nm, RES_VALID, 1);
  endtask

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Ramp pattern: feed order and hold of the last point.
    for (int k = 0; k < 40; k++) load(k, k % 16, k / 16);
    load(45, 15, 15);
    set_eng(0, 0, 0, 0);
    pulse_start();
    wait_result("t1_done");
    chk("t1_hold", {L_Y, L_X}, 8'h27);
    chk("t1_count", RES_COUNT, 13);

    // All points on C1.
    for (int k = 0; k < 40; k++) load(k, 5, 5);
    set_eng(5, 5, 0, 0);
    pulse_start();
    wait_result("t2_done");
    chk("t2_c1", RES_C1, 8'h55);
    chk("t2_c2", RES_C2, 8'h00);
    chk("t2_count", RES_COUNT, 40);

    // Two clusters, only one inside a circle.
    for (int k = 0; k < 40; k++) load(k, k < 20 ? 0 : 15, k < 20 ? 0 : 15);
    set_eng(3, 2, 12, 12);
    pulse_start();
    wait_result("t3_done");
    chk("t3_c1", RES_C1, 8'h23);
    chk("t3_count", RES_COUNT, 20);

    // Reset in FEED cycle 17, then restart with a same-cycle write to point 0.
    pulse_start();
    repeat (18) tick();
    #2 RST = 1'b1;
    #1;
    chk("t4_busy", BUSY, 0);
    chk("t4_l_rst", L_RST, 1);
    chk("t4_valid", RES_VALID, 0);
    tick();
    RST = 1'b0;
    LD_VALID = 1'b1; LD_ADDR = 6'd0; LD_X = 4'd1; LD_Y = 4'd1;
    START = 1'b1;
    tick();
    LD_VALID = 1'b0; START = 1'b0;
    chk("t4_rstd_busy", BUSY, 1);
    tick();
    chk("t4_first_pt", {L_Y, L_X}, 8'h11);
    wait_result("t4_done");
    chk("t4_count", RES_COUNT, 20);

    // Write during FEED and START during WAIT are both ignored.
    pulse_start();
    repeat (5) tick();
    load(3, 9, 9);
    repeat (36) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_result("t5_done");
    pulse_start();
    repeat (4) tick();
    chk("t5_old_pt3", {L_Y, L_X}, 8'h00);
    wait_result("t5b_done");

`ifdef LASER_HOST_TIMEOUT_EN
    eng_mute = 1'b1;
    pulse_start();
    wait_result("t6_done");
    chk("t6_err", RES_ERR, 1);
    chk("t6_count", RES_COUNT, 0);
    chk("t6_c1", RES_C1, 0);
    eng_mute = 1'b0;
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side driver and checker for the two-circle LASER search engine.
- Holds a 40-entry target-point buffer that software or a bench preloads.
- On start it resets the engine, streams the points on X/Y one per cycle, then waits for the engine's DONE pulse.
- It captures the two circle centres, scores them by counting covered points, and presents a result.

Parameters:
- NUM_OBJ, 40, number of points streamed per run; the engine requires exactly 40.
- RADIUS_SQ, 16, coverage test: a point is covered if dx*dx+dy*dy <= RADIUS_SQ.
- TIMEOUT_CYC, 16383, max cycles spent in WAIT (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; asynchronous, active-high.
- LD_VALID  in  1  buffer write strobe.
- LD_ADDR  in  6  buffer write index, 0..NUM_OBJ-1.
- LD_X  in  4  point x.
- LD_Y  in  4  point y.
- START  in  1  one-cycle run request.
- L_RST  out  1  synchronous reset to the engine.
- L_X  out  4  point x to the engine.
- L_Y  out  4  point y to the engine.
- L_C1X  in  4  engine circle-1 x.
- L_C1Y  in  4  engine circle-1 y.
- L_C2X  in  4  engine circle-2 x.
- L_C2Y  in  4  engine circle-2 y.
- L_DONE  in  1  engine done pulse.
- BUSY  out  1  run in progress.
- RES_VALID  out  1  result fields valid.
- RES_C1  out  8  captured {C1Y,C1X}.
- RES_C2  out  8  captured {C2Y,C2X}.
- RES_COUNT  out  6  covered-point count, 0..40.
- RES_ERR  out  1  run aborted (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async): state=IDLE; L_RST=1; L_X=L_Y=0; BUSY=0; RES_VALID=0; RES_C1=RES_C2=0; RES_COUNT=0; RES_ERR=0. Buffer contents are not reset.
- Loading: in IDLE or RESULT, LD_VALID=1 with LD_ADDR<NUM_OBJ writes {LD_Y,LD_X} on that edge. LD_ADDR>=NUM_OBJ is ignored. LD_VALID in any other state is ignored.
- FSM states: IDLE, RSTD, FEED, WAIT, SCORE, RESULT.
- IDLE or RESULT with START=1 -> RSTD. That edge clears RES_VALID/RES_ERR and sets BUSY=1. If LD_VALID and START are high in the same cycle, the write lands first and the run sees the new point.
- RSTD (1 cycle): L_RST=1 -> FEED.
- FEED (exactly NUM_OBJ cycles): L_RST=0. In the k-th FEED cycle (k=0..39), L_X/L_Y = buffer[k], registered so it is stable for the whole cycle. After k=39 -> WAIT; L_X/L_Y hold the last point.
- The engine samples point k on the edge ending FEED cycle k. No gap and no stall is permitted.
- WAIT: on the first cycle L_DONE=1, capture RES_C1={L_C1Y,L_C1X} and RES_C2={L_C2Y,L_C2X} -> SCORE. L_DONE seen outside WAIT is ignored.
- SCORE (NUM_OBJ cycles): index j=0..39, one point per cycle.
  - dx=|x-cx| and dy=|y-cy|, 4-bit unsigned; squares are 8-bit; the sum is 9-bit.
  - Point is covered if it is within RADIUS_SQ of C1 or of C2. A point covered by both circles counts once.
  - The 6-bit accumulator is cleared on entry to SCORE.
  - After j=39 -> RESULT.
- RESULT: RES_VALID=1 and BUSY=0. Results hold until the next START or reset.
- L_RST is 1 in IDLE, RSTD and RESULT; 0 in FEED, WAIT and SCORE.
- START while BUSY is ignored.
- Reset mid-run: returns to IDLE immediately, with all outputs at their reset values.

Optional Feature:
- Macro LASER_HOST_TIMEOUT_EN.
- Defined: a 14-bit counter clears on entry to WAIT and counts each WAIT cycle. When it reaches TIMEOUT_CYC without L_DONE, the FSM goes to RESULT with:
  - RES_ERR=1, RES_VALID=1;
  - RES_C1, RES_C2 and RES_COUNT all 0;
  - L_RST=1 from the next cycle.
- Not defined: WAIT has no bound, the counter is not built, and RES_ERR is constant 0.

Test Plan:
- Load buffer[k]=(x=k%16, y=k/16); START -> L_RST high for exactly 1 cycle, then L_X/L_Y show (0,0),(1,0)...(7,2) on 40 consecutive cycles, then hold (7,2).
- Load all 40 points = (5,5); a behavioural engine model returns C1=(5,5), C2=(0,0) -> RES_C1=8'h55, RES_C2=8'h00, RES_COUNT=40, RES_VALID=1.
- 20 points at (0,0) and 20 at (15,15); engine returns C1=(3,2), C2=(12,12) -> (3,2) gives 13, covered; (3,3) from (15,15) gives 18, not covered -> RES_COUNT=20.
- Assert RST during FEED cycle 17 -> BUSY=0, L_RST=1, RES_VALID=0 at once; a new START replays from point 0.
- LD_VALID during FEED with LD_ADDR=3 -> buffer unchanged, and the next run feeds the old point 3. START during WAIT -> ignored.
- With LASER_HOST_TIMEOUT_EN and TIMEOUT_CYC=100, never pulse L_DONE -> after 100 WAIT cycles RES_ERR=1, RES_VALID=1, RES_COUNT=0.
